// File: rtl/rv32i_multicycle_core.sv
// Multicycle RV32I core: a FETCH/DECODE/EXEC/MEM/WB sequencer around one shared ALU,
// a unified word-addressed memory and a 32x32 register file.

module rv32i_mem #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [29:0] i_word_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata_c
);
    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0]   regs [0:MEM_WORDS-1];
    logic [AW-1:0] w_idx;

    // Out-of-range word addresses wrap modulo the memory size.
    assign w_idx     = AW'(i_word_addr % 30'(MEM_WORDS));
    assign o_rdata_c = regs[w_idx];

    always_ff @(posedge i_clk) begin
        if (i_we) regs[w_idx] <= i_wdata;
    end
endmodule

module rv32i_regfile (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rs1_data_c,
    output logic [31:0] o_rs2_data_c
);
    logic [31:0] regs [0:31];

    assign o_rs1_data_c = (i_rs1 == 5'd0) ? 32'd0 : regs[i_rs1];
    assign o_rs2_data_c = (i_rs2 == 5'd0) ? 32'd0 : regs[i_rs2];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (i_we && (i_rd != 5'd0)) begin
            regs[i_rd] <= i_wdata;
        end
    end
endmodule

module rv32i_datapath #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic i_clk,
    input logic i_rst
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    state_t      r_state;
    logic [31:0] r_pc, r_old_pc, r_ir, r_a, r_b, r_imm, r_alu, r_mdr;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm, w_alu_b, w_alu, w_mem_rdata, w_rs1_data, w_rs2_data;
    logic [31:0] w_st_mask, w_st_data, w_st_word, w_ld_shift, w_ld_val, w_rf_wdata;
    logic [29:0] w_mem_word;
    logic [4:0]  w_shamt, w_lane_sh;
    logic        w_alt, w_taken, w_writes_rd, w_rf_we, w_mem_we;

    assign w_opcode  = r_ir[6:0];
    assign w_funct3  = r_ir[14:12];
    assign w_lane_sh = {r_alu[1:0], 3'b000};

    always_comb begin
        case (w_opcode)
            OP_LUI, OP_AUIPC: w_imm = {r_ir[31:12], 12'd0};
            OP_JAL:    w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
            OP_BRANCH: w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
            OP_STORE:  w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            default:   w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
        endcase
    end

    // Shared ALU; bit 30 selects SUB/SRA, but for immediates only on the shift-right encoding.
    always_comb begin
        w_alu   = 32'd0;
        w_alu_b = (w_opcode == OP_OP) ? r_b : r_imm;
        w_alt   = r_ir[30] & ((w_opcode == OP_OP) | (w_funct3 == 3'b101));
        w_shamt = w_alu_b[4:0];
        case (w_funct3)
            3'b000:  w_alu = w_alt ? (r_a - w_alu_b) : (r_a + w_alu_b);
            3'b001:  w_alu = r_a << w_shamt;
            3'b010:  w_alu = {31'd0, $signed(r_a) < $signed(w_alu_b)};
            3'b011:  w_alu = {31'd0, r_a < w_alu_b};
            3'b100:  w_alu = r_a ^ w_alu_b;
            3'b101:  w_alu = w_alt ? 32'($signed(r_a) >>> w_shamt) : (r_a >> w_shamt);
            3'b110:  w_alu = r_a | w_alu_b;
            default: w_alu = r_a & w_alu_b;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = (r_a == r_b);
            3'b001:  w_taken = (r_a != r_b);
            3'b100:  w_taken = ($signed(r_a) < $signed(r_b));
            3'b101:  w_taken = ($signed(r_a) >= $signed(r_b));
            3'b110:  w_taken = (r_a < r_b);
            3'b111:  w_taken = (r_a >= r_b);
            default: w_taken = 1'b0;
        endcase
    end

    // Sub-word stores merge into the addressed word through a lane mask.
    always_comb begin
        case (w_funct3[1:0])
            2'b00:   w_st_mask = 32'h0000_00FF << w_lane_sh;
            2'b01:   w_st_mask = 32'h0000_FFFF << w_lane_sh;
            default: w_st_mask = 32'hFFFF_FFFF;
        endcase
        w_st_data  = (w_funct3[1:0] == 2'b10) ? r_b : (r_b << w_lane_sh);
        w_st_word  = (w_mem_rdata & ~w_st_mask) | (w_st_data & w_st_mask);
        w_ld_shift = r_mdr >> w_lane_sh;
        case (w_funct3)
            3'b000:  w_ld_val = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            3'b001:  w_ld_val = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            3'b100:  w_ld_val = {24'd0, w_ld_shift[7:0]};
            3'b101:  w_ld_val = {16'd0, w_ld_shift[15:0]};
            default: w_ld_val = r_mdr;
        endcase
    end

    assign w_writes_rd = (w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) || (w_opcode == OP_JAL)
                      || (w_opcode == OP_JALR) || (w_opcode == OP_LOAD) || (w_opcode == OP_OPIMM)
                      || (w_opcode == OP_OP);
    assign w_rf_we    = (r_state == S_WB) && w_writes_rd;
    assign w_rf_wdata = (w_opcode == OP_LOAD) ? w_ld_val : r_alu;
    assign w_mem_we   = (r_state == S_MEM) && (w_opcode == OP_STORE) && !i_rst;
    assign w_mem_word = (r_state == S_FETCH) ? r_pc[31:2] : r_alu[31:2];

    rv32i_mem #(.MEM_WORDS(MEM_WORDS)) mem_inst (
        .i_clk(i_clk), .i_we(w_mem_we), .i_word_addr(w_mem_word),
        .i_wdata(w_st_word), .o_rdata_c(w_mem_rdata)
    );

    rv32i_regfile rf (
        .i_clk(i_clk), .i_rst(i_rst), .i_we(w_rf_we),
        .i_rs1(r_ir[19:15]), .i_rs2(r_ir[24:20]), .i_rd(r_ir[11:7]), .i_wdata(w_rf_wdata),
        .o_rs1_data_c(w_rs1_data), .o_rs2_data_c(w_rs2_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_old_pc <= 32'd0;
            r_ir     <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_imm    <= 32'd0;
            r_alu    <= 32'd0;
            r_mdr    <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir     <= w_mem_rdata;
                    r_old_pc <= r_pc;
                    r_pc     <= r_pc + 32'd4;
                    r_state  <= S_DECODE;
                end
                S_DECODE: begin
                    r_a     <= w_rs1_data;
                    r_b     <= w_rs2_data;
                    r_imm   <= w_imm;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_WB;
                    case (w_opcode)
                        OP_LUI:   r_alu <= r_imm;
                        OP_AUIPC: r_alu <= r_old_pc + r_imm;
                        OP_JAL: begin
                            r_alu <= r_old_pc + 32'd4;
                            r_pc  <= r_old_pc + r_imm;
                        end
                        OP_JALR: begin
                            r_alu <= r_old_pc + 32'd4;
                            r_pc  <= (r_a + r_imm) & ~32'd1;
                        end
                        OP_BRANCH: begin
                            if (w_taken) r_pc <= r_old_pc + r_imm;
                            r_state <= S_FETCH;
                        end
                        OP_LOAD, OP_STORE: begin
                            r_alu   <= r_a + r_imm;
                            r_state <= S_MEM;
                        end
                        OP_OPIMM, OP_OP: r_alu <= w_alu;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    r_mdr   <= w_mem_rdata;
                    r_state <= (w_opcode == OP_LOAD) ? S_WB : S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end
endmodule

module rv32i_multicycle_core #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    rv32i_datapath #(.MEM_WORDS(MEM_WORDS), .RESET_PC(RESET_PC)) dp (
        .i_clk(clk),
        .i_rst(rst)
    );
endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// Directed bench for rv32i_multicycle_core: branch program, load/store program, reset behaviour.

module tb_rv32i_multicycle_core;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    logic [31:0] prog [$];

    rv32i_multicycle_core #(.MEM_WORDS(256), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [31:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] off, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {off[11:5], rs2, rs1, f3, off[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [31:0] off);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] xr(input int idx);
        return dut.dp.rf.regs[idx];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Words beyond the program become zero, which decodes as a NOP opcode.
    task automatic load_prog();
        for (int i = 0; i < 256; i++)
            dut.dp.mem_inst.regs[i] <= (i < prog.size()) ? prog[i] : 32'd0;
        ticks(1);
    endtask

    initial begin
        logic seen;
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        ticks(3);

        // Branch program: six taken skips, two not-taken, halt at word 30.
        prog = {};
        prog.push_back(addi(5, 0, 10));   prog.push_back(addi(6, 0, 10));
        prog.push_back(enc_b(8, 5, 6, 3'b000)); prog.push_back(addi(5, 0, 0));
        prog.push_back(addi(7, 0, 10));   prog.push_back(addi(8, 0, 20));
        prog.push_back(enc_b(8, 7, 8, 3'b001)); prog.push_back(addi(7, 0, 0));
        prog.push_back(addi(9, 0, -5));   prog.push_back(addi(10, 0, 5));
        prog.push_back(enc_b(8, 9, 10, 3'b100)); prog.push_back(addi(9, 0, 0));
        prog.push_back(addi(11, 0, 5));   prog.push_back(addi(12, 0, -5));
        prog.push_back(enc_b(8, 11, 12, 3'b101)); prog.push_back(addi(11, 0, 0));
        prog.push_back(addi(13, 0, 10));  prog.push_back(addi(14, 0, 20));
        prog.push_back(enc_b(8, 13, 14, 3'b110)); prog.push_back(addi(13, 0, 0));
        prog.push_back(addi(15, 0, 20));  prog.push_back(addi(16, 0, 10));
        prog.push_back(enc_b(8, 15, 16, 3'b111)); prog.push_back(addi(15, 0, 0));
        prog.push_back(addi(17, 0, -1));  prog.push_back(addi(18, 0, 1));
        prog.push_back(enc_b(8, 17, 18, 3'b110)); prog.push_back(addi(19, 0, 77));
        prog.push_back(addi(21, 0, 11));  prog.push_back(enc_b(8, 5, 21, 3'b000));
        prog.push_back(enc_jal(0, 0));
        load_prog();

        check("reset_pc", dut.dp.r_pc, 32'h0);
        check("reset_ir", dut.dp.r_ir, 32'h0);
        check("reset_x5", xr(5), 32'h0);
        rst = 1'b0;

        ticks(3);
        check("first_wb_not_yet", xr(5), 32'h0);
        ticks(1);
        check("first_wb_edge4", xr(5), 32'd10);

        ticks(96);
        check("beq_taken_x5", xr(5), 32'd10);
        check("bne_taken_x7", xr(7), 32'd10);
        check("blt_taken_x9", xr(9), 32'hFFFF_FFFB);
        check("bge_taken_x11", xr(11), 32'd5);
        check("bltu_taken_x13", xr(13), 32'd10);
        check("bgeu_taken_x15", xr(15), 32'd20);
        check("bltu_not_taken_x19", xr(19), 32'd77);
        check("addi_neg_x17", xr(17), 32'hFFFF_FFFF);
        check("halt_old_pc_by_100", dut.dp.r_old_pc, 32'h78);

        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            ticks(1);
            if (dut.dp.r_pc == 32'h78) seen = 1'b1;
        end
        check("halt_pc_reached", {31'd0, seen}, 32'd1);
        ticks(4);
        check("halt_pc_stable", dut.dp.r_pc, 32'h78);
        check("halt_x20_untouched", xr(20), 32'h0);

        // Load/store program, not-taken fallthrough, JAL link, SUB and SRLI.
        rst = 1'b1;
        prog = {};
        prog.push_back({20'h12345, 5'd1, 7'b0110111});
        prog.push_back(addi(1, 1, 32'h678));
        prog.push_back(addi(2, 0, 32'h100));
        prog.push_back(enc_s(0, 1, 2, 3'b010));
        prog.push_back(enc_i(3, 2, 3'b000, 3, 7'b0000011));
        prog.push_back(enc_i(3, 2, 3'b100, 4, 7'b0000011));
        prog.push_back(addi(5, 0, 10));
        prog.push_back(addi(6, 0, 11));
        prog.push_back(enc_b(8, 5, 6, 3'b000));
        prog.push_back(addi(5, 0, 0));
        prog.push_back(addi(7, 0, -1));
        prog.push_back(enc_s(1, 7, 2, 3'b000));
        prog.push_back(enc_i(1, 2, 3'b000, 8, 7'b0000011));
        prog.push_back(enc_i(0, 2, 3'b101, 9, 7'b0000011));
        prog.push_back(enc_i(0, 2, 3'b001, 10, 7'b0000011));
        prog.push_back(enc_jal(11, 8));
        prog.push_back(addi(12, 0, 1));
        prog.push_back({7'b0100000, 5'd2, 5'd7, 3'b000, 5'd13, 7'b0110011});
        prog.push_back(enc_i(28, 7, 3'b101, 14, 7'b0010011));
        prog.push_back(enc_jal(0, 0));
        load_prog();
        check("rst_clears_x19", xr(19), 32'h0);
        check("rst_pc_zero", dut.dp.r_pc, 32'h0);
        rst = 1'b0;

        ticks(200);
        check("lui_addi_x1", xr(1), 32'h1234_5678);
        check("lb_0x103", xr(3), 32'h0000_0012);
        check("lbu_0x103", xr(4), 32'h0000_0012);
        check("beq_not_taken_x5", xr(5), 32'h0);
        check("sb_merge_word", dut.dp.mem_inst.regs[64], 32'h1234_FF78);
        check("lb_sign_0x101", xr(8), 32'hFFFF_FFFF);
        check("lhu_0x100", xr(9), 32'h0000_FF78);
        check("lh_0x100", xr(10), 32'hFFFF_FF78);
        check("jal_link_x11", xr(11), 32'h0000_0040);
        check("jal_skipped_x12", xr(12), 32'h0);
        check("sub_x13", xr(13), 32'hFFFF_FEFF);
        check("srli_x14", xr(14), 32'h0000_000F);
        check("halt2_old_pc", dut.dp.r_old_pc, 32'h4C);

        // Reset clears every architectural register.
        rst = 1'b1;
        ticks(1);
        for (int i = 1; i < 32; i++) check($sformatf("rst_clear_x%0d", i), xr(i), 32'h0);
        rst = 1'b0;

        // Abort ADDI x1 between EXEC and WB.
        ticks(7);
        check("abort_pre_x1", xr(1), 32'h1234_5000);
        rst = 1'b1;
        ticks(1);
        check("abort_x1_cleared", xr(1), 32'h0);
        check("abort_pc", dut.dp.r_pc, 32'h0);
        check("abort_ir", dut.dp.r_ir, 32'h0);
        rst = 1'b0;
        ticks(4);
        check("restart_lui_x1", xr(1), 32'h1234_5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
